// File: rtl/uart_msg_printer.sv
// UART message server: a trigger byte selects a NUL-terminated ROM slot, which is
// streamed byte by byte into the UART transmitter. ESC aborts a message in progress.
module uart_msg_printer #(
  parameter int          NUM_MSGS   = 4,
  parameter int          SEL_BITS   = 2,
  parameter int          SLOT_BITS  = 5,
  parameter logic [7:0]  TRIG_BASE  = 8'h30,
  parameter logic [7:0]  ABORT_CHAR = 8'h1B
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    rx_data,
  input  logic                          new_rx_data,
  output logic [7:0]                    tx_data,
  output logic                          new_tx_data,
  input  logic                          tx_busy,
  output logic [SEL_BITS+SLOT_BITS-1:0] rom_addr,
  input  logic [7:0]                    rom_data,
  output logic                          busy,
  output logic                          done,
  output logic [SEL_BITS-1:0]           cur_msg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2
  } state_t;

  localparam logic [8:0] MSG_LIMIT = 9'(NUM_MSGS);

  state_t               state;
  logic [SEL_BITS-1:0]  msg;
  logic [SLOT_BITS-1:0] offset;

  logic [7:0] rx_index;
  logic       trigger;
  logic       abort;
  logic       end_of_msg;
  logic       last_offset;
  logic       send_ok;

  // Trigger range test is an 8-bit unsigned difference, so bytes below TRIG_BASE wrap high.
  assign rx_index    = rx_data - TRIG_BASE;
  assign trigger     = new_rx_data && ({1'b0, rx_index} < MSG_LIMIT);
  assign abort       = (state != IDLE) && new_rx_data && (rx_data == ABORT_CHAR);
  assign end_of_msg  = (rom_data == 8'h00);
  assign last_offset = &offset;
  assign send_ok     = (state == SEND) && !abort && !end_of_msg && !tx_busy;

  // Strobe and completion are decided in the SEND cycle itself; reset suppresses both.
  assign new_tx_data = send_ok && !rst;
  assign done        = (state == SEND) && !abort && !rst &&
                       (end_of_msg || (send_ok && last_offset));
  assign tx_data     = rom_data;
  assign busy        = (state != IDLE);
  assign rom_addr    = {msg, offset};
  assign cur_msg     = msg;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      msg    <= '0;
      offset <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (trigger) begin
            msg    <= rx_index[SEL_BITS-1:0];
            offset <= '0;
            state  <= FETCH;
          end
        end
        FETCH: begin
          state <= abort ? IDLE : SEND;
        end
        SEND: begin
          if (abort || end_of_msg) begin
            state <= IDLE;
          end else if (!tx_busy) begin
            // On the last slot byte the offset wraps to 0 and is never fetched.
            offset <= offset + 1'b1;
            state  <= last_offset ? IDLE : FETCH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
